// File: rtl/boss_damage_ctrl.sv
// boss_damage_ctrl
// Once per game tick, tests the player bullet against the boss hitbox and
// keeps the boss hit-point counter. Drives the HP bus, the one-hot attack
// phase flags, a hit/consume pulse and a sticky dead flag.
//
// Ports
//   clk_i              system clock
//   rst_i              synchronous active-high reset
//   tick_i             one-cycle game-step strobe
//   bullet_valid_i     bullet on screen
//   reimu_bullet{x,y}_i bullet centre (10 b each)
//   boss{x,y}_i        boss centre (10 b each)
//   boss_i             boss present
//   bosshp_o           current HP
//   hit_o              one-cycle pulse when a hit is accepted
//   bullet_consume_o   same pulse, back to the bullet logic
//   enma1_o..enma4_o   one-hot phase flags (all 0 when HP is 0)
//   boss_dead_o        HP reached 0, held until reset
//
// state | meaning
// IDLE  | waiting for tick; burns invulnerability ticks
// CHECK | overlap test on the latched coordinates
// APPLY | apply damage if the overlap flag is set
// DEAD  | terminal, only reset leaves
module boss_damage_ctrl #(
    parameter int HP_MAX  = 450,
    parameter int DMG     = 10,
    parameter int BOSS_HW = 32,
    parameter int BOSS_HH = 32,
    parameter int BUL_H   = 4,
    parameter int IFRAMES = 4,
    parameter int P2      = 337,
    parameter int P3      = 225,
    parameter int P4      = 112
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       bullet_valid_i,
    input  logic [9:0] reimu_bulletx_i,
    input  logic [9:0] reimu_bullety_i,
    input  logic [9:0] bossx_i,
    input  logic [9:0] bossy_i,
    input  logic       boss_i,
    output logic [9:0] bosshp_o,
    output logic       hit_o,
    output logic       bullet_consume_o,
    output logic       enma1_o,
    output logic       enma2_o,
    output logic       enma3_o,
    output logic       enma4_o,
    output logic       boss_dead_o
);

    localparam int          CW    = (IFRAMES < 1) ? 1 : $clog2(IFRAMES + 1);
    localparam logic [10:0] X_LIM = 11'(BOSS_HW + BUL_H);
    localparam logic [10:0] Y_LIM = 11'(BOSS_HH + BUL_H);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_APPLY, S_DEAD} state_t;

    state_t          state_q, state_d;
    logic [9:0]      hp_q, hp_d;
    logic [CW-1:0]   cd_q, cd_d;
    logic [9:0]      bx_q, bx_d, by_q, by_d, sx_q, sx_d, sy_q, sy_d;
    logic            bval_q, bval_d, bact_q, bact_d;
    logic            ovl_q, ovl_d;
    logic            hit_q, hit_d;
    logic [10:0]     dx, dy;
    logic            ovl_calc;

    // Magnitude as larger minus smaller keeps the distance free of wrap.
    always_comb begin
        dx = (bx_q >= sx_q) ? ({1'b0, bx_q} - {1'b0, sx_q}) : ({1'b0, sx_q} - {1'b0, bx_q});
        dy = (by_q >= sy_q) ? ({1'b0, by_q} - {1'b0, sy_q}) : ({1'b0, sy_q} - {1'b0, by_q});
    end

    assign ovl_calc = bval_q & bact_q & (dx <= X_LIM) & (dy <= Y_LIM);

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        cd_d    = cd_q;
        bx_d    = bx_q;
        by_d    = by_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        bval_d  = bval_q;
        bact_d  = bact_q;
        ovl_d   = ovl_q;
        hit_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    if (cd_q != '0) begin
                        cd_d = cd_q - CW'(1);
                    end else begin
                        bx_d    = reimu_bulletx_i;
                        by_d    = reimu_bullety_i;
                        sx_d    = bossx_i;
                        sy_d    = bossy_i;
                        bval_d  = bullet_valid_i;
                        bact_d  = boss_i;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                ovl_d   = ovl_calc;
                state_d = S_APPLY;
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (ovl_q) begin
                    hit_d = 1'b1;
                    cd_d  = CW'(IFRAMES);
                    if (hp_q <= 10'(DMG)) begin
                        hp_d    = '0;
                        state_d = S_DEAD;
                    end else begin
                        hp_d = hp_q - 10'(DMG);
                    end
                end
            end
            S_DEAD: begin
                state_d = S_DEAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hp_q    <= 10'(HP_MAX);
            cd_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            bval_q  <= 1'b0;
            bact_q  <= 1'b0;
            ovl_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            cd_q    <= cd_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            bval_q  <= bval_d;
            bact_q  <= bact_d;
            ovl_q   <= ovl_d;
            hit_q   <= hit_d;
        end
    end

    assign bosshp_o         = hp_q;
    assign hit_o            = hit_q;
    assign bullet_consume_o = hit_q;
    assign boss_dead_o      = (state_q == S_DEAD);

    assign enma1_o = (hp_q > 10'(P2));
    assign enma2_o = (hp_q > 10'(P3)) && (hp_q <= 10'(P2));
    assign enma3_o = (hp_q > 10'(P4)) && (hp_q <= 10'(P3));
    assign enma4_o = (hp_q != '0) && (hp_q <= 10'(P4));

endmodule

// File: tb/tb_boss_damage_ctrl.sv
module tb_boss_damage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, rst2, tick2, bv, bs;
    logic [9:0] bx, by, sx, sy;
    logic [9:0] hp1, hp2;
    logic       hit1, con1, e1, e2, e3, e4, dead1;
    logic       hit2, con2, f1, f2, f3, f4, dead2;

    int total = 0;
    int bad   = 0;
    int exp_hp;

    typedef struct {
        int hp;
        int fl;
        int dead;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    typedef struct {
        int x;
        int y;
        int v;
        int b;
        int h;
    } vec_t;

    boss_damage_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .bullet_valid_i(bv),
        .reimu_bulletx_i(bx), .reimu_bullety_i(by), .bossx_i(sx), .bossy_i(sy),
        .boss_i(bs), .bosshp_o(hp1), .hit_o(hit1), .bullet_consume_o(con1),
        .enma1_o(e1), .enma2_o(e2), .enma3_o(e3), .enma4_o(e4), .boss_dead_o(dead1)
    );

    boss_damage_ctrl #(.DMG(100), .IFRAMES(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .tick_i(tick2), .bullet_valid_i(bv),
        .reimu_bulletx_i(bx), .reimu_bullety_i(by), .bossx_i(sx), .bossy_i(sy),
        .boss_i(bs), .bosshp_o(hp2), .hit_o(hit2), .bullet_consume_o(con2),
        .enma1_o(f1), .enma2_o(f2), .enma3_o(f3), .enma4_o(f4), .boss_dead_o(dead2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Phase flags {enma4,enma3,enma2,enma1} for the default thresholds.
    function automatic int flags_of(input int hp);
        if (hp == 0)        return 0;
        else if (hp > 337)  return 1;
        else if (hp > 225)  return 2;
        else if (hp > 112)  return 4;
        else                return 8;
    endfunction

    // Monitors: pop an expectation whenever a DUT presents a hit.
    always @(negedge clk) begin
        exp_t e;
        chk("dut1_consume_eq_hit", con1, hit1);
        if (hit1) begin
            chk("dut1_hit_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("dut1_sb_hp", hp1, e.hp);
                chk("dut1_sb_flags", {e4, e3, e2, e1}, e.fl);
                chk("dut1_sb_dead", dead1, e.dead);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("dut2_consume_eq_hit", con2, hit2);
        if (hit2) begin
            chk("dut2_hit_expected", int'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("dut2_sb_hp", hp2, e.hp);
                chk("dut2_sb_flags", {f4, f3, f2, f1}, e.fl);
                chk("dut2_sb_dead", dead2, e.dead);
            end
        end
    end

    task automatic reset1();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hp = 450;
    endtask

    task automatic set_xy(input int x, input int y, input int v, input int b);
        bx = 10'(x);
        by = 10'(y);
        sx = 10'd320;
        sy = 10'd100;
        bv = v[0];
        bs = b[0];
    endtask

    // One tick on the default instance; exp_hit is hand-decided by the caller.
    task automatic tick1(input int exp_hit, input string name, input bit scramble = 1'b0);
        if (exp_hit != 0) begin
            exp_hp = (exp_hp <= 10) ? 0 : exp_hp - 10;
            q1.push_back('{exp_hp, flags_of(exp_hp), int'(exp_hp == 0)});
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (scramble) begin
            bx = 10'd900;
            by = 10'd900;
        end
        @(negedge clk);
        chk({name, "_lat1"}, hit1, 0);
        @(negedge clk);
        chk({name, "_lat2"}, hit1, exp_hit);
        @(negedge clk);
        chk({name, "_hp"}, hp1, exp_hp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   cd_pat[6];
        int   d2[5];
        vecs = '{
            '{356, 100, 1, 1, 1}, '{357, 100, 1, 1, 0},
            '{284, 100, 1, 1, 1}, '{283, 100, 1, 1, 0},
            '{320, 136, 1, 1, 1}, '{320, 137, 1, 1, 0},
            '{320,  64, 1, 1, 1}, '{320,  63, 1, 1, 0},
            '{356, 136, 1, 1, 1}, '{320, 100, 0, 1, 0},
            '{320, 100, 1, 0, 0}
        };
        cd_pat = '{1, 0, 0, 0, 0, 1};
        d2     = '{350, 250, 150, 50, 0};

        rst = 1'b1; rst2 = 1'b1; tick = 1'b0; tick2 = 1'b0;
        set_xy(320, 100, 1, 1);
        reset1();
        rst2 = 1'b0;

        chk("rst_hp", hp1, 450);
        chk("rst_flags", {e4, e3, e2, e1}, 1);
        chk("rst_hit", hit1, 0);
        chk("rst_dead", dead1, 0);

        // Direct hit; coordinates moved away during CHECK must not matter.
        tick1(1, "direct", 1'b1);

        foreach (vecs[i]) begin
            reset1();
            set_xy(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].b);
            tick1(vecs[i].h, $sformatf("bnd%0d", i));
        end

        reset1();
        set_xy(320, 100, 1, 1);
        foreach (cd_pat[i]) tick1(cd_pat[i], $sformatf("cool%0d", i));
        chk("cool_final_hp", hp1, 430);

        // Kill: 45 hits, each followed by enough ticks to drain invulnerability.
        reset1();
        for (int i = 0; i < 45; i++) begin
            tick1(1, $sformatf("kill%0d", i));
            if (exp_hp == 340) chk("phase_at340", {e4, e3, e2, e1}, 1);
            if (exp_hp == 330) chk("phase_at330", {e4, e3, e2, e1}, 2);
            if (exp_hp == 220) chk("phase_at220", {e4, e3, e2, e1}, 4);
            if (exp_hp == 110) chk("phase_at110", {e4, e3, e2, e1}, 8);
            if (i < 44) repeat (4) tick1(0, "kill_cd");
        end
        chk("kill_hp", hp1, 0);
        chk("kill_dead", dead1, 1);
        chk("kill_flags", {e4, e3, e2, e1}, 0);
        tick1(0, "dead_tick");
        chk("dead_hold", dead1, 1);

        // Reset during CHECK.
        reset1();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_check_hp", hp1, 450);
        tick1(1, "post_rst_check");

        // Reset during APPLY.
        reset1();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_apply_hp", hp1, 450);
        tick1(1, "post_rst_apply");

        // Reset wins over a simultaneous tick.
        reset1();
        rst = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prio_hp", hp1, 450);

        // Heavy damage, no invulnerability: saturates at zero.
        chk("dut2_rst_hp", hp2, 450);
        foreach (d2[i]) begin
            q2.push_back('{d2[i], flags_of(d2[i]), int'(d2[i] == 0)});
            tick2 = 1'b1;
            @(negedge clk);
            tick2 = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("dut2_hp%0d", i), hp2, d2[i]);
        end
        tick2 = 1'b1;
        @(negedge clk);
        tick2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("dut2_dead_hp", hp2, 0);
        chk("dut2_dead", dead2, 1);

        chk("sb1_drain", q1.size(), 0);
        chk("sb2_drain", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
